// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM with ALU decoder
// Moore state machine; only pcen sees zero, only illegal sees op outside the next-state logic.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     cur;
   logic       pcwrite;
   logic       branch;
   logic [1:0] aluop;
   logic       legal_op;

   assign legal_op = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                     (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= FETCH;
      end else begin
         case (cur)
            FETCH:   cur <= DECODE;
            DECODE: begin
               case (op)
                  OP_LW, OP_SW: cur <= MEMADR;
                  OP_RTYPE:     cur <= EXECUTE;
                  OP_BEQ:       cur <= BRANCH;
                  OP_ADDI:      cur <= ADDIEX;
                  OP_J:         cur <= JUMP;
                  default:      cur <= FETCH;
               endcase
            end
            MEMADR:  cur <= (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   cur <= MEMWB;
            EXECUTE: cur <= ALUWB;
            ADDIEX:  cur <= ADDIWB;
            // terminal states and the unused encodings 12-15 all fall back to FETCH
            default: cur <= FETCH;
         endcase
      end
   end

   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      aluop    = 2'b00;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      case (cur)
         FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
         DECODE:  alusrcb = 2'b11;
         MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         MEMRD:   iord = 1'b1;
         MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
         MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
         EXECUTE: begin alusrca = 1'b1; aluop = 2'b10; end
         ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; end
         BRANCH:  begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
         ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         ADDIWB:  regwrite = 1'b1;
         JUMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
         default: ;
      endcase
      // reset suppresses every write immediately, including the cycle of the reset edge
      if (reset) begin
         pcwrite  = 1'b0;
         branch   = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
      end
      pcen    = pcwrite | (branch & zero);
      illegal = (cur == DECODE) && !legal_op && !reset;
   end

   always_comb begin
      alucontrol = 3'b010;
      case (aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   assign state = cur;

endmodule
